// File: rtl/riscuin_mc_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, write-back.
// Resolves branches/jumps, traps on data faults and misaligned targets, counts retirements.
module riscuin_mc_sequencer #(
   parameter int ADDR_WIDTH = 10,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
   parameter int CNT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [31:0]           imem_data,
   output logic [31:0]           instr,
   input  logic                  branch,
   input  logic                  jal,
   input  logic                  jalr,
   input  logic                  mem_r,
   input  logic                  mem_w,
   input  logic                  reg_w_req,
   input  logic                  halt_req,
   input  logic [2:0]            funct3,
   input  logic [31:0]           rs1_data,
   input  logic [31:0]           rs2_data,
   input  logic [31:0]           imm,
   output logic                  dbus_req,
   input  logic                  dbus_ack,
   input  logic                  dbus_err,
   output logic                  reg_w,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [31:0]           pc_link,
   output logic                  pc_end,
   output logic                  trap,
   output logic [CNT_WIDTH-1:0]  instret
);

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

   state_t      state_reg;
   logic        taken_reg;
   logic [31:0] target_reg;

   logic [31:0] pc_byte;
   logic [31:0] target_next;
   logic        cond;
   logic        taken_next;
   logic        exec_misalign;
   logic        wb_misalign;
   logic        unused_target_bits;

   assign pc_byte   = 32'({pc, 2'b00});
   assign pc_link   = pc_byte + 32'd4;
   assign imem_addr = pc;

   always_comb begin
      cond = 1'b0;
      case (funct3)
         3'b000:  cond = (rs1_data == rs2_data);
         3'b001:  cond = (rs1_data != rs2_data);
         3'b100:  cond = ($signed(rs1_data) <  $signed(rs2_data));
         3'b101:  cond = ($signed(rs1_data) >= $signed(rs2_data));
         3'b110:  cond = (rs1_data <  rs2_data);
         3'b111:  cond = (rs1_data >= rs2_data);
         default: cond = 1'b0;
      endcase
   end

   assign taken_next    = jal | jalr | (branch & cond);
   assign target_next   = jalr ? ((rs1_data + imm) & 32'hFFFF_FFFE) : (pc_byte + imm);
   // A taken target that is not word aligned ends execution with a trap in WB.
   assign exec_misalign = taken_next & target_next[1];
   assign wb_misalign   = taken_reg & target_reg[1];

   assign unused_target_bits = ^{target_reg[31:ADDR_WIDTH+2], target_reg[0]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg  <= FETCH;
         pc         <= RESET_PC;
         instr      <= '0;
         instret    <= '0;
         pc_end     <= 1'b0;
         trap       <= 1'b0;
         reg_w      <= 1'b0;
         imem_req   <= 1'b0;
         dbus_req   <= 1'b0;
         taken_reg  <= 1'b0;
         target_reg <= '0;
      end else begin
         case (state_reg)
            FETCH: begin
               if (imem_req && imem_ack) begin
                  instr     <= imem_data;
                  imem_req  <= 1'b0;
                  state_reg <= DECODE;
               end else begin
                  imem_req <= 1'b1;
               end
            end
            DECODE: state_reg <= EXEC;
            EXEC: begin
               taken_reg  <= taken_next;
               target_reg <= target_next;
               if (mem_r || mem_w) begin
                  dbus_req  <= 1'b1;
                  state_reg <= MEM;
               end else begin
                  reg_w     <= reg_w_req & ~exec_misalign;
                  state_reg <= WB;
               end
            end
            MEM: begin
               if (dbus_err) begin
                  dbus_req  <= 1'b0;
                  trap      <= 1'b1;
                  pc_end    <= 1'b1;
                  state_reg <= HALT;
               end else if (dbus_ack) begin
                  dbus_req  <= 1'b0;
                  reg_w     <= reg_w_req & ~wb_misalign;
                  state_reg <= WB;
               end
            end
            WB: begin
               reg_w <= 1'b0;
               if (wb_misalign) begin
                  trap      <= 1'b1;
                  pc_end    <= 1'b1;
                  state_reg <= HALT;
               end else begin
                  instret <= instret + CNT_WIDTH'(1);
                  pc      <= taken_reg ? target_reg[ADDR_WIDTH+1:2] : pc + ADDR_WIDTH'(1);
                  // Falling off the end of the address space stops like an explicit halt.
                  if (halt_req || (!taken_reg && (&pc))) begin
                     pc_end    <= 1'b1;
                     state_reg <= HALT;
                  end else begin
                     imem_req  <= 1'b1;
                     state_reg <= FETCH;
                  end
               end
            end
            HALT: state_reg <= HALT;
            default: state_reg <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_riscuin_mc_sequencer.sv
// Bench for riscuin_mc_sequencer: directed scenarios plus randomized instruction streams
// checked against an instruction-level reference model.
module tb_riscuin_mc_sequencer;
   localparam int AW = 4;
   localparam int CW = 8;
   localparam logic [AW-1:0] RPC = '0;

   logic          clk, rst;
   logic          imem_req, imem_ack;
   logic [AW-1:0] imem_addr, pc;
   logic [31:0]   imem_data, instr, rs1_data, rs2_data, imm, pc_link;
   logic          branch, jal, jalr, mem_r, mem_w, reg_w_req, halt_req;
   logic [2:0]    funct3;
   logic          dbus_req, dbus_ack, dbus_err, reg_w, pc_end, trap;
   logic [CW-1:0] instret;

   riscuin_mc_sequencer #(.ADDR_WIDTH(AW), .RESET_PC(RPC), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_data(imem_data), .instr(instr), .branch(branch), .jal(jal), .jalr(jalr),
      .mem_r(mem_r), .mem_w(mem_w), .reg_w_req(reg_w_req), .halt_req(halt_req),
      .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
      .dbus_req(dbus_req), .dbus_ack(dbus_ack), .dbus_err(dbus_err), .reg_w(reg_w),
      .pc(pc), .pc_link(pc_link), .pc_end(pc_end), .trap(trap), .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit        branch, jal, jalr, mem_r, mem_w, reg_w_req, halt_req, err;
      bit [2:0]  funct3;
      bit [31:0] rs1, rs2, imm, word;
      int        fwait, dwait;
   } item_t;

   int          n_compared = 0;
   int          n_mismatched = 0;
   int          n_txn = 0;
   int unsigned m_pc, m_instret;
   bit          m_halt, m_trap;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic finish_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   endtask

   function automatic item_t plain_item();
      item_t it;
      it = '{default: 0};
      it.word      = $urandom;
      it.reg_w_req = 1'b1;
      return it;
   endfunction

   function automatic bit [31:0] pick_val();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'd5;
         3: return 32'hFFFF_FFFF;
         4: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   function automatic item_t rand_item();
      item_t it;
      int k, s;
      it = plain_item();
      k = int'($urandom_range(0, 9));
      it.reg_w_req = 1'($urandom_range(0, 1));
      it.halt_req  = ($urandom_range(0, 24) == 0);
      it.fwait     = int'($urandom_range(0, 2));
      it.dwait     = int'($urandom_range(0, 3));
      it.funct3    = 3'($urandom_range(0, 7));
      it.rs1       = pick_val();
      it.rs2       = pick_val();
      s = int'($urandom_range(0, 16)) - 8;
      it.imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'(s * 4);
      case (k)
         3, 4: it.branch = 1'b1;
         5: it.jal = 1'b1;
         6: it.jalr = 1'b1;
         7: it.mem_r = 1'b1;
         8: it.mem_w = 1'b1;
         default: ;
      endcase
      if (it.mem_r || it.mem_w) it.err = ($urandom_range(0, 5) == 0);
      return it;
   endfunction

   task automatic drive_item(input item_t it);
      branch = it.branch; jal = it.jal; jalr = it.jalr; mem_r = it.mem_r; mem_w = it.mem_w;
      reg_w_req = it.reg_w_req; halt_req = it.halt_req; funct3 = it.funct3;
      rs1_data = it.rs1; rs2_data = it.rs2; imm = it.imm; imem_data = it.word;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; imem_ack = 1'b0; dbus_ack = 1'b0; dbus_err = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("rst_pc", pc, RPC);
      check_val("rst_instret", instret, 0);
      check_val("rst_pc_end", pc_end, 0);
      check_val("rst_trap", trap, 0);
      check_val("rst_reg_w", reg_w, 0);
      check_val("rst_imem_req", imem_req, 0);
      check_val("rst_dbus_req", dbus_req, 0);
      check_val("rst_instr", instr, 0);
      rst = 1'b1;
      @(negedge clk);
      check_val("imem_req_after_rst", imem_req, 1);
      m_pc = RPC; m_instret = 0; m_halt = 1'b0; m_trap = 1'b0;
   endtask

   // Entered at a negedge where the fetch of this instruction is (or should be) pending.
   task automatic exec_one(input item_t it, output int cyc, output int ndbus, output int nregw);
      bit [31:0] pcb, target;
      bit        cnd, taken, mem, fault, misal, done, fetched, dacked;
      int        fcnt, dcnt, exp_cyc, exp_regw;
      int unsigned pc_before;
      pcb = 32'(m_pc << 2);
      case (it.funct3)
         3'd0: cnd = (it.rs1 == it.rs2);
         3'd1: cnd = (it.rs1 != it.rs2);
         3'd4: cnd = ($signed(it.rs1) <  $signed(it.rs2));
         3'd5: cnd = ($signed(it.rs1) >= $signed(it.rs2));
         3'd6: cnd = (it.rs1 <  it.rs2);
         3'd7: cnd = (it.rs1 >= it.rs2);
         default: cnd = 1'b0;
      endcase
      taken  = it.jal || it.jalr || (it.branch && cnd);
      target = it.jalr ? ((it.rs1 + it.imm) & ~32'd1) : (pcb + it.imm);
      mem    = it.mem_r || it.mem_w;
      fault  = mem && it.err;
      misal  = !fault && taken && target[1];
      exp_cyc  = it.fwait + 3 + (mem ? it.dwait + 1 : 0) + (fault ? 0 : 1);
      exp_regw = (fault || misal) ? 0 : int'(it.reg_w_req);
      check_val("pc_link", pc_link, pcb + 32'd4);

      drive_item(it);
      cyc = 0; ndbus = 0; nregw = 0; fcnt = 0; dcnt = 0;
      done = 1'b0; fetched = 1'b0; dacked = 1'b0;
      while (!done && cyc < 64) begin
         cyc++;
         if (reg_w) nregw++;
         if (dbus_req) ndbus++;
         imem_ack = 1'b0; dbus_ack = 1'b0; dbus_err = 1'b0;
         if (imem_req && !fetched) begin
            if (fcnt == it.fwait) begin imem_ack = 1'b1; fetched = 1'b1; end
            else fcnt++;
         end
         if (dbus_req && !dacked) begin
            if (dcnt == it.dwait) begin dbus_ack = !it.err; dbus_err = it.err; dacked = 1'b1; end
            else dcnt++;
         end
         @(negedge clk);
         if (pc_end || (imem_req && fetched)) done = 1'b1;
      end
      imem_ack = 1'b0; dbus_ack = 1'b0; dbus_err = 1'b0;
      if (!done) begin
         check_val("txn_timeout", 1, 0);
         finish_run();
      end

      pc_before = m_pc;
      if (fault || misal) begin
         m_halt = 1'b1; m_trap = 1'b1;
      end else begin
         m_instret = (m_instret + 1) % (1 << CW);
         if (taken) m_pc = (target >> 2) & ((1 << AW) - 1);
         else if (m_pc == (1 << AW) - 1) begin m_pc = 0; m_halt = 1'b1; end
         else m_pc = m_pc + 1;
         if (it.halt_req) m_halt = 1'b1;
      end
      n_txn++;
      check_val("cycles", cyc, exp_cyc);
      check_val("reg_w_cycles", nregw, exp_regw);
      check_val("dbus_req_cycles", ndbus, mem ? it.dwait + 1 : 0);
      check_val("instr", instr, it.word);
      check_val("pc", pc, m_pc);
      check_val("instret", instret, m_instret);
      check_val("pc_end", pc_end, m_halt);
      check_val("trap", trap, m_trap);
      $display("txn %0d: pc %0d->%0d taken=%0b mem=%0b cyc=%0d instret=%0d end=%0b trap=%0b",
               n_txn, pc_before, pc, taken, mem, cyc, instret, pc_end, trap);
   endtask

   task automatic check_halt_hold();
      repeat (3) begin
         imem_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_val("halt_imem_req", imem_req, 0);
         check_val("halt_dbus_req", dbus_req, 0);
         check_val("halt_reg_w", reg_w, 0);
         check_val("halt_pc_end", pc_end, 1);
         check_val("halt_pc", pc, m_pc);
      end
      imem_ack = 1'b0;
   endtask

   initial begin
      #500000;
      check_val("global_timeout", 1, 0);
      finish_run();
   end

   initial begin
      item_t it;
      int c, d, r;
      rst = 1'b0; imem_ack = 1'b0; dbus_ack = 1'b0; dbus_err = 1'b0;
      drive_item(plain_item());

      // Straight-line code, immediate fetch ack.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         exec_one(plain_item(), c, d, r);
         check_val("straight_cycles", c, 4);
         check_val("straight_reg_w", r, 1);
      end
      check_val("straight_pc", pc, 3);
      check_val("straight_instret", instret, 3);

      // Branches: jump to 4, then the three conditions.
      do_reset();
      it = plain_item(); it.jal = 1'b1; it.imm = 32'd16;
      exec_one(it, c, d, r);
      check_val("jal_pc", pc, 4);
      it = plain_item(); it.branch = 1'b1; it.funct3 = 3'b101; it.rs1 = 5; it.rs2 = 5; it.imm = 8;
      exec_one(it, c, d, r);
      check_val("bge_pc", pc, 6);
      it.funct3 = 3'b111; it.rs1 = 32'hFFFF_FFFF; it.rs2 = 1;
      exec_one(it, c, d, r);
      check_val("bgeu_pc", pc, 8);
      it.funct3 = 3'b100; it.rs1 = 7; it.rs2 = 7;
      exec_one(it, c, d, r);
      check_val("blt_pc", pc, 9);

      // jalr aligned and misaligned.
      do_reset();
      exec_one(plain_item(), c, d, r);
      exec_one(plain_item(), c, d, r);
      check_val("jalr_link", pc_link, 32'hC);
      it = plain_item(); it.jalr = 1'b1; it.rs1 = 32'h11; it.imm = 32'h3;
      exec_one(it, c, d, r);
      check_val("jalr_pc", pc, 5);
      do_reset();
      exec_one(plain_item(), c, d, r);
      exec_one(plain_item(), c, d, r);
      it = plain_item(); it.jalr = 1'b1; it.rs1 = 32'h2; it.imm = 0;
      exec_one(it, c, d, r);
      check_val("jalr_mis_trap", trap, 1);
      check_val("jalr_mis_pc", pc, 2);
      check_val("jalr_mis_reg_w", r, 0);
      check_halt_hold();

      // Load with three wait states, then a faulting load.
      do_reset();
      it = plain_item(); it.mem_r = 1'b1; it.dwait = 3;
      exec_one(it, c, d, r);
      check_val("load_cycles", c, 8);
      check_val("load_dbus", d, 4);
      it.err = 1'b1;
      exec_one(it, c, d, r);
      check_val("load_err_trap", trap, 1);
      check_val("load_err_reg_w", r, 0);
      check_halt_hold();

      // End of address space, and explicit halt.
      do_reset();
      it = plain_item(); it.jal = 1'b1; it.imm = 32'd60;
      exec_one(it, c, d, r);
      exec_one(plain_item(), c, d, r);
      check_val("wrap_pc", pc, 0);
      check_val("wrap_end", pc_end, 1);
      check_halt_hold();
      do_reset();
      it = plain_item(); it.halt_req = 1'b1;
      exec_one(it, c, d, r);
      check_val("halt_end", pc_end, 1);
      check_val("halt_instret", instret, 1);
      check_val("halt_trap", trap, 0);

      // Reset while the data bus request is pending.
      do_reset();
      it = plain_item(); it.jal = 1'b1; it.imm = 32'd20;
      exec_one(it, c, d, r);
      it = plain_item(); it.mem_w = 1'b1;
      drive_item(it);
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      c = 0;
      while (!dbus_req && c < 10) begin @(negedge clk); c++; end
      check_val("mem_reached", dbus_req, 1);
      rst = 1'b0;
      @(negedge clk);
      check_val("mem_rst_dbus", dbus_req, 0);
      check_val("mem_rst_pc", pc, RPC);
      check_val("mem_rst_imem_req", imem_req, 0);
      dbus_ack = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      check_val("mem_rst_fetch", imem_req, 1);
      check_val("mem_rst_dbus2", dbus_req, 0);
      dbus_ack = 1'b0;
      m_pc = RPC; m_instret = 0; m_halt = 1'b0; m_trap = 1'b0;
      exec_one(plain_item(), c, d, r);

      // Retired counter wraps without side effects.
      do_reset();
      it = plain_item(); it.jal = 1'b1; it.imm = 0;
      for (int i = 0; i < 260; i++) exec_one(it, c, d, r);
      check_val("instret_wrap", instret, 4);
      check_val("instret_wrap_end", pc_end, 0);

      // Randomized instruction streams.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (m_halt) begin
            check_halt_hold();
            do_reset();
         end
         exec_one(rand_item(), c, d, r);
      end

      finish_run();
   end
endmodule

// File: doc/riscuin_mc_sequencer.md
RISCUIN_MC_SEQUENCER -- requirements
Module: riscuin_mc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning instruction word-address width.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning word address loaded at reset.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, meaning retired-instruction counter width.
REQ-004 SHALL have ports, one per line:
 clk  in  1  single clock, rising edge.
 rst  in  1  reset, synchronous, active-low.
 imem_req  out  1  instruction fetch request.
 imem_addr  out  ADDR_WIDTH  fetch word address (= pc).
 imem_ack  in  1  fetch data valid.
 imem_data  in  32  fetched instruction.
 instr  out  32  latched instruction for the decoder.
 branch, jal, jalr, mem_r, mem_w, reg_w_req, halt_req  in  1 each  decoded controls.
 funct3  in  3  branch condition.
 rs1_data, rs2_data, imm  in  32 each  operands.
 dbus_req  out  1  data bus request.
 dbus_ack  in  1  data bus complete.
 dbus_err  in  1  data bus access fault.
 reg_w  out  1  register write strobe.
 pc  out  ADDR_WIDTH  current word address.
 pc_link  out  32  byte address of pc+4.
 pc_end  out  1  halted.
 trap  out  1  halted by fault.
 instret  out  CNT_WIDTH  retired count.

Function
REQ-005 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-006 FETCH SHALL assert imem_req with imem_addr=pc until imem_ack=1; on ack latch imem_data into instr, go DECODE.
REQ-007 DECODE SHALL last exactly one cycle, then go EXEC.
REQ-008 EXEC SHALL last one cycle: register taken flag and 32-bit target; go MEM if mem_r|mem_w, else WB.
REQ-009 Branch condition by funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge (>=), 110 unsigned lt, 111 unsigned ge (>=); 010/011 not taken.
REQ-010 Target: branch/jal = {pc,2'b00}+imm; jalr = (rs1_data+imm) with bit0 cleared; 32-bit modulo arithmetic.
REQ-011 jal/jalr SHALL always be taken; pc_link = {pc,2'b00}+4 truncated to 32 bits.
REQ-012 MEM SHALL hold dbus_req=1 until dbus_ack or dbus_err; ack -> WB; err -> HALT with trap=1, no reg_w.
REQ-013 WB SHALL last one cycle: reg_w=1 iff reg_w_req; pc <= taken ? target[ADDR_WIDTH+1:2] : pc+1; instret increments; go FETCH.
REQ-014 Taken target with bit1=1 SHALL go HALT from WB with trap=1, no reg_w, pc unchanged, instret unchanged.
REQ-015 halt_req in WB SHALL retire the instruction, then go HALT with pc_end=1, trap=0.
REQ-016 pc+1 wrapping past all-ones on a not-taken instruction SHALL retire, load 0, go HALT with pc_end=1.
REQ-017 instret SHALL wrap to 0 after all-ones without other effect.
REQ-018 HALT SHALL be absorbing until reset; imem_req, dbus_req, reg_w held 0; pc_end=1.
REQ-019 reg_w, imem_req, dbus_req SHALL be 0 in all states other than those stated.
REQ-020 Minimum latency: 4 cycles per non-memory instruction with imem_ack in first FETCH cycle; 5 with single-cycle dbus_ack.

Reset
REQ-021 rst=0 at a clock edge SHALL, from any state, set state FETCH, pc=RESET_PC, instr=0, instret=0, pc_end=0, trap=0, reg_w=0, imem_req=0, dbus_req=0.
REQ-022 rst=0 during MEM SHALL drop dbus_req on the next cycle; pending ack afterwards ignored.
REQ-023 imem_req SHALL assert in the first cycle after rst returns to 1.

Verification
REQ-024 Straight line: 3 non-branch reg_w_req=1 instructions, ack immediate -> pc 0,1,2,3; reg_w one cycle each every 4 cycles; instret=3.
REQ-025 Branches: funct3=101, rs1=rs2=5, imm=8 at pc=4 -> pc=6; funct3=111, rs1=0xFFFF_FFFF, rs2=1 -> taken; funct3=100 rs1=rs2 -> pc+1.
REQ-026 jalr rs1=0x11, imm=0x3 at pc=2 -> pc=5, pc_link=0xC; jalr rs1=0x2, imm=0 -> trap=1, pc_end=1, pc=2.
REQ-027 Load with dbus_ack after 3 wait cycles -> dbus_req high 4 cycles, instruction takes 8 cycles; dbus_err instead -> trap=1, reg_w never 1.
REQ-028 ADDR_WIDTH=4, pc=15 not taken -> pc=0, pc_end=1; halt_req -> pc_end=1, instret+1; rst=0 in MEM -> next cycle dbus_req=0, pc=RESET_PC, state FETCH.
